bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Shares one downstream Bus_if master port between two upstream requesters: m0 (instruction fetch) and m1 (data access).
- Sits between the CPU's fetch and memory stages and the address-decoding bus.
- Holds the grant for a whole transaction, including slave stall cycles.
- Gives each requester the same stall/data_rd handshake that the slaves provide.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports; mask width is DATA_WIDTH/8.

Ports:
- clk  in  1  system clock, driven from clk.base
- rst  in  1  synchronous, active-high reset, driven from clk.rst
- m{0,1}_address  in  ADDR_WIDTH each  requester address
- m{0,1}_read, m{0,1}_write  in  1 each  requester strobes; held stable until the requester's stall is low
- m{0,1}_data_wr  in  DATA_WIDTH each  write data
- m{0,1}_mask  in  DATA_WIDTH/8 each  byte enables
- m{0,1}_stall  out  1 each  request not yet completed
- m{0,1}_data_rd  out  DATA_WIDTH each  read data; valid only in the owner's completion cycle
- s_address, s_data_wr, s_mask  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  to downstream bus
- s_read, s_write  out  1 each  downstream strobes
- s_stall  in  1  downstream busy
- s_data_rd  in  DATA_WIDTH  downstream read data
- grant_o  out  2  one-hot current owner; 00 means idle

Behaviour:
- Definitions:
  - req_i = mi_read | mi_write.
  - Completion = owner req & !s_stall.
- States: IDLE, OWN0, OWN1, held in a state register updated on the posedge of clk.
- IDLE:
  - s_read, s_write, s_address, s_data_wr and s_mask all drive 0.
  - Any pending request wins per the priority rule and enters OWNx next cycle.
  - Arbitration latency is exactly 1 cycle.
- OWNx:
  - s_* are combinationally muxed from mx_*.
  - Grant is held while s_stall=1; the other requester cannot preempt.
- On completion of OWNx:
  - If the other requester is pending, go directly to OWNy next cycle (no idle bubble).
  - Else if x still requests (a new back-to-back access), stay in OWNx.
  - Else go to IDLE.
- Requester stall:
  - mi_stall = req_i & !(state==OWNi & !s_stall).
  - A non-requesting port always reads stall=0.
- m0_data_rd and m1_data_rd both equal s_data_rd (broadcast); a requester samples it only when its own stall is low.
- Abort: if the owner deasserts req while in OWNx, the arbiter goes to IDLE next cycle, or to the other requester if it is pending.
- Fixed priority (default): m1 beats m0 when both are pending in the same decision cycle.
- Reset:
  - While rst=1, s_read=s_write=0 and grant_o=00 combinationally.
  - The state register becomes IDLE at the next edge, even mid-transaction.
  - mi_stall = req_i while rst=1.
- Reset values: state IDLE, grant_o 00, all s_* 0.
- A requester asserting read and write simultaneously is illegal; the arbiter passes both through unchanged.

Optional Feature:
- Macro: BUS_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - Adds a last_owner register (reset 0).
  - When both requesters are pending, the one that is not last_owner wins.
  - last_owner updates on every completion.
  - The direct-handoff rule already alternates continuous requesters 1,0,1,0.
  - The stay-in-OWNx rule applies only when the other requester is idle.
- Undefined:
  - Fixed priority m1 > m0 as above.
  - No last_owner register.

Decomposition:
- Shared package bus_arb_pkg:
  - ArbState_t enum {IDLE, OWN0, OWN1}.
  - MasterId_t (1 bit).
  - Constants ARB_MASTER_INST=0 and ARB_MASTER_DATA=1.
- One natural combinational sub-module: arb_pick.
  - Inputs: req[1:0], last_owner, rr_enable.
  - Outputs: winner id and valid.
  - Reused by the next-state logic in both IDLE and the completion handoff.

Test Plan:
1. Single read, no stall:
   - Stimulus: m0_read=1, m0_address=0x0000_0100 at cycle 0; s_stall=0; s_data_rd=0xDEAD_BEEF.
   - Response: m0_stall=1 at cycle 0; at cycle 1 s_read=1, s_address=0x100, m0_stall=0, m0_data_rd=0xDEAD_BEEF, grant_o=01; cycle 2 returns to IDLE.
2. Simultaneous requests, fixed priority:
   - Stimulus: m0 read 0x200 and m1 write 0x300, both at cycle 0; s_stall=0.
   - Response: cycle 1 grant_o=10, s_write=1, s_address=0x300; cycle 2 grant_o=01, s_read, s_address=0x200; m0_stall high through cycle 1.
3. Slave stall hold:
   - Stimulus: m1 owns the bus; s_stall=1 for 3 cycles; m0 requests during the stall.
   - Response: s_address stays stable and grant_o=10 for 4 cycles; m0 is granted in the cycle after m1 completes.
4. Round robin (BUS_ARBITER_ROUND_ROBIN_EN):
   - Stimulus: both requesters assert continuously; s_stall=0.
   - Response: grant_o sequence 10,01,10,01.
   - Without the macro: same sequence via handoff. With only m1 held, m1 stays granted.
5. Reset mid-transaction:
   - Stimulus: rst=1 during OWN0 with s_stall=1.
   - Response: s_read=0 in the same cycle; grant_o=00; next cycle state IDLE; m0_stall=1 while the request is held.
6. Abort:
   - Stimulus: the m0 owner drops m0_read while s_stall=1.
   - Response: next cycle grant_o=00, s_read=0; no completion is reported to m1.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state, master-id types and helpers for bus_arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } ArbState_t;

    typedef logic MasterId_t;

    localparam MasterId_t ARB_MASTER_INST = 1'b0;
    localparam MasterId_t ARB_MASTER_DATA = 1'b1;

    function automatic ArbState_t own_state(input MasterId_t id);
        return (id == ARB_MASTER_DATA) ? OWN1 : OWN0;
    endfunction

    function automatic logic [1:0] id_onehot(input MasterId_t id);
        return (id == ARB_MASTER_DATA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/stall bus shared by requesters, arbiter and downstream slave
interface bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   data_wr;
    logic [DATA_WIDTH/8-1:0] mask;
    logic                    stall;
    logic [DATA_WIDTH-1:0]   data_rd;

    modport master (
        output address, read, write, data_wr, mask,
        input  stall, data_rd
    );

    modport slave (
        input  address, read, write, data_wr, mask,
        output stall, data_rd
    );
endinterface

// File: rtl/bus_arbiter_arb_pick.sv
// rtl/bus_arbiter_arb_pick.sv - two-way winner selection, fixed m1 priority or alternate-on-tie
module arb_pick
    import bus_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  MasterId_t  last_owner_i,
    input  logic       rr_enable_i,
    output MasterId_t  winner_o,
    output logic       valid_o
);
    always_comb begin
        valid_o  = |req_i;
        winner_o = ARB_MASTER_INST;
        if (req_i == 2'b11) begin
            winner_o = rr_enable_i ? ~last_owner_i : ARB_MASTER_DATA;
        end else if (req_i[1]) begin
            winner_o = ARB_MASTER_DATA;
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares one downstream bus between fetch (m0) and data (m1) requesters
// Define BUS_ARBITER_ROUND_ROBIN_EN to alternate the winner on ties instead of fixed m1 priority.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    bus_if.slave       m0,
    bus_if.slave       m1,
    bus_if.master      s,
    output logic [1:0] grant_o
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    ArbState_t             state_q, state_d;
    logic [1:0]            req;
    logic                  owner_valid, owner_req, complete;
    MasterId_t             owner_id;
    logic [1:0]            pick_req;
    MasterId_t             pick_winner;
    logic                  pick_valid;
    MasterId_t             last_owner;
    logic                  rr_enable;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [DATA_WIDTH-1:0] wdata_mux;
    logic [MASK_WIDTH-1:0] mask_mux;
    logic                  read_mux, write_mux;

    assign req         = {m1.read | m1.write, m0.read | m0.write};
    assign owner_valid = (state_q != IDLE);
    assign owner_id    = (state_q == OWN1) ? ARB_MASTER_DATA : ARB_MASTER_INST;
    assign owner_req   = owner_valid & req[owner_id];
    assign complete    = owner_req & ~s.stall & ~rst;
    // While a transaction is owned only the other requester can be a handoff target.
    assign pick_req    = owner_valid ? (req & ~id_onehot(owner_id)) : req;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    MasterId_t last_owner_q, last_owner_d;

    always_comb begin
        last_owner_d = last_owner_q;
        if (complete) begin
            last_owner_d = owner_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= ARB_MASTER_INST;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    assign last_owner = last_owner_q;
    assign rr_enable  = 1'b1;
`else
    assign last_owner = ARB_MASTER_INST;
    assign rr_enable  = 1'b0;
`endif

    arb_pick u_pick (
        .req_i        (pick_req),
        .last_owner_i (last_owner),
        .rr_enable_i  (rr_enable),
        .winner_o     (pick_winner),
        .valid_o      (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = own_state(pick_winner);
                end
            end
            OWN0, OWN1: begin
                // Completion or abort releases the bus; a completing owner keeps it if nobody else waits.
                if (!owner_req || !s.stall) begin
                    if (pick_valid) begin
                        state_d = own_state(pick_winner);
                    end else if (!owner_req) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_o   = 2'b00;
        read_mux  = 1'b0;
        write_mux = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        mask_mux  = '0;
        if (owner_valid && !rst) begin
            grant_o = id_onehot(owner_id);
            if (owner_id == ARB_MASTER_DATA) begin
                read_mux  = m1.read;
                write_mux = m1.write;
                addr_mux  = m1.address;
                wdata_mux = m1.data_wr;
                mask_mux  = m1.mask;
            end else begin
                read_mux  = m0.read;
                write_mux = m0.write;
                addr_mux  = m0.address;
                wdata_mux = m0.data_wr;
                mask_mux  = m0.mask;
            end
        end
    end

    assign s.read     = read_mux;
    assign s.write    = write_mux;
    assign s.address  = addr_mux;
    assign s.data_wr  = wdata_mux;
    assign s.mask     = mask_mux;

    assign m0.stall   = req[0] & ~(complete & (owner_id == ARB_MASTER_INST));
    assign m1.stall   = req[1] & ~(complete & (owner_id == ARB_MASTER_DATA));
    assign m0.data_rd = s.data_rd;
    assign m1.data_rd = s.data_rd;
endmodule
